// File: rtl/mux32_x4_if.sv
// Bundle of the mux32_x4 data/select bus for benches and wrappers.
// The master drives the source words and select; the slave side returns the results.
interface mux32_x4_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [1:0]       select;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;
  logic             out_changed;

  modport master (
    output in0, in1, in2, in3, select,
    input  out, out_q, sel_q, out_changed
  );

  modport slave (
    input  in0, in1, in2, in3, select,
    output out, out_q, sel_q, out_changed
  );
endinterface

// File: rtl/mux32_x4.sv
// Four-way WIDTH-bit selector with a zero-latency output plus a registered copy,
// registered select and a one-cycle change flag.
module mux32_x4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_changed
);

  // An X/Z select matches no item and falls to the zero default.
  always_comb begin
    out = '0;
    case (select)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      sel_q       <= 2'b00;
      out_changed <= 1'b0;
    end else begin
      out_q       <= out;
      sel_q       <= select;
      out_changed <= (out != out_q);
    end
  end

endmodule

// File: tb/tb_mux32_x4.sv
// Directed bench for mux32_x4: combinational selection first, then the registered path.
module tb_mux32_x4;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mux32_x4_if #(.WIDTH(32)) bus ();

  mux32_x4 #(.WIDTH(32)) dut (
    .in0        (bus.in0),
    .in1        (bus.in1),
    .in2        (bus.in2),
    .in3        (bus.in3),
    .select     (bus.select),
    .out        (bus.out),
    .clk        (clk),
    .rst        (rst),
    .out_q      (bus.out_q),
    .sel_q      (bus.sel_q),
    .out_changed(bus.out_changed)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Combinational path, no clock running.
    bus.in0 = 32'd0; bus.in1 = 32'd1; bus.in2 = 32'd2; bus.in3 = 32'd3;
    bus.select = 2'b00; #5; check("comb_sel00", bus.out, 32'd0);
    bus.select = 2'b01; #5; check("comb_sel01", bus.out, 32'd1);
    bus.select = 2'b10; #5; check("comb_sel10", bus.out, 32'd2);
    bus.select = 2'b11; #5; check("comb_sel11", bus.out, 32'd3);

    bus.in3 = 32'hFFFF8080; #1;
    check("comb_data_follow", bus.out, 32'hFFFF8080);

    bus.select = 2'b01; #1;
    bus.in0 = 32'hDEADBEEF; bus.in2 = 32'hDEADBEEF; bus.in3 = 32'hDEADBEEF; #1;
    check("comb_unselected", bus.out, 32'd1);

    // Registered path.
    bus.in0 = 32'd0; bus.in2 = 32'd2; bus.in3 = 32'd3;
    rst = 1'b1;
    clk_en = 1'b1;
    tick(); tick();
    check("rst_out_q", bus.out_q, 32'd0);
    check("rst_sel_q", {30'd0, bus.sel_q}, 32'd0);
    check("rst_changed", {31'd0, bus.out_changed}, 32'd0);

    rst = 1'b0; bus.select = 2'b10;
    tick();
    check("rel_out_q", bus.out_q, 32'd2);
    check("rel_sel_q", {30'd0, bus.sel_q}, 32'd2);
    check("rel_changed", {31'd0, bus.out_changed}, 32'd1);
    tick();
    check("hold_changed", {31'd0, bus.out_changed}, 32'd0);
    check("hold_out_q", bus.out_q, 32'd2);

    // Toggle select between equal words: only the first capture changes out_q.
    bus.in0 = 32'd7; bus.in1 = 32'd7; bus.select = 2'b00;
    tick();
    check("tog0_out_q", bus.out_q, 32'd7);
    check("tog0_changed", {31'd0, bus.out_changed}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] s;
      s = (i % 2 == 1) ? 2'b01 : 2'b00;
      bus.select = s;
      bus.in2 = 32'h1000 + i;  // unselected, must not disturb anything
      tick();
      check("tog_out_q", bus.out_q, 32'd7);
      check("tog_sel_q", {30'd0, bus.sel_q}, {30'd0, s});
      check("tog_changed", {31'd0, bus.out_changed}, 32'd0);
    end

    // Reset mid-operation while out_q holds 3.
    bus.in3 = 32'd3; bus.select = 2'b11;
    tick();
    check("pre_rst_out_q", bus.out_q, 32'd3);
    check("pre_rst_changed", {31'd0, bus.out_changed}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_q", bus.out_q, 32'd0);
    check("mid_rst_sel_q", {30'd0, bus.sel_q}, 32'd0);
    check("mid_rst_changed", {31'd0, bus.out_changed}, 32'd0);
    check("mid_rst_out", bus.out, 32'd3);
    bus.in3 = 32'h0000ABCD; #1;
    check("rst_out_follow", bus.out, 32'h0000ABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
